instr_issuer: RTL and testbench

- Host-side instruction feeder for the 9-bit simple processor; drives the processor's DIN and Run and consumes its Done.
- Host pushes instruction words, and MVI immediates, into an internal FIFO.
- Issuer pops words in order and sequences them onto DIN with the exact per-step timing the processor's T0–T3 control FSM expects.
- Provides back-to-back issue, filtering of unsupported opcodes, and a completed-instruction counter.

---
 rtl/instr_issuer_if.sv | 27 ++
 rtl/instr_issuer.sv | 160 ++++++++++++++++
 tb/tb_instr_issuer.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_issuer_if.sv
// Host/processor-side bundle of the instruction issuer.
// The master side is the host plus processor; the slave side is the issuer.
interface instr_issuer_if #(
  parameter int unsigned AW = 3
);
  logic [8:0]  wr_data_i;
  logic        wr_en_i;
  logic        full_o;
  logic [AW:0] count_o;
  logic        go_i;
  logic [8:0]  din_o;
  logic        run_o;
  logic        done_i;
  logic        busy_o;
  logic        drop_err_o;
  logic [7:0]  instr_cnt_o;

  modport master (
    output wr_data_i, wr_en_i, go_i, done_i,
    input  full_o, count_o, din_o, run_o, busy_o, drop_err_o, instr_cnt_o
  );

  modport slave (
    input  wr_data_i, wr_en_i, go_i, done_i,
    output full_o, count_o, din_o, run_o, busy_o, drop_err_o, instr_cnt_o
  );
endinterface

// File: rtl/instr_issuer.sv
// FIFO-fed instruction issuer driving DIN/Run of the 9-bit simple processor.
// Optional INSTR_ISSUER_SINGLE_STEP_EN adds step_i: each rising edge grants one issue.
module instr_issuer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic clk,
  input  logic rst,
`ifdef INSTR_ISSUER_SINGLE_STEP_EN
  input  logic step_i,
`endif
  instr_issuer_if.slave bus
);
  localparam int unsigned CW = AW + 1;
  localparam logic [2:0] OP_MVI = 3'b001;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  logic [8:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  state_e        state_q, state_d;
  logic [8:0]    din_q, din_d;
  logic          run_q, run_d;
  logic          busy_q, busy_d;
  logic          drop_q, drop_d;
  logic [7:0]    icnt_q, icnt_d;
  logic          mvi_q, mvi_d;
  logic          push, pop, issue, eligible, token_ok;
  logic [8:0]    head;
  logic [2:0]    head_op;

  assign head    = mem_q[rptr_q];
  assign head_op = head[8:6];
  assign push    = bus.wr_en_i && !full_q;

  // An MVI may only leave once its immediate is already queued behind it.
  assign eligible = bus.go_i && token_ok && !head_op[2] &&
                    (((head_op != OP_MVI) && (count_q >= CW'(1))) ||
                     ((head_op == OP_MVI) && (count_q >= CW'(2))));

`ifdef INSTR_ISSUER_SINGLE_STEP_EN
  logic step_q, token_q, token_d;

  // Token set by a Step rising edge, consumed by an issue; extra steps are lost.
  always_comb begin
    token_d = token_q | (step_i & ~step_q);
    if (issue) token_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q  <= 1'b0;
      token_q <= 1'b0;
    end else begin
      step_q  <= step_i;
      token_q <= token_d;
    end
  end

  assign token_ok = token_q;
`else
  assign token_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    din_d   = din_q;
    run_d   = 1'b0;
    drop_d  = 1'b0;
    icnt_d  = icnt_q;
    mvi_d   = mvi_q;
    pop     = 1'b0;
    issue   = 1'b0;
    case (state_q)
      S_IDLE: begin
        din_d = '0;
        if (eligible) begin
          issue = 1'b1;
        end else if (bus.go_i && (count_q != '0) && head_op[2]) begin
          pop    = 1'b1;
          drop_d = 1'b1;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        if (mvi_q) begin
          pop   = 1'b1;
          din_d = head;
        end else begin
          din_d = '0;
        end
      end
      S_WAIT: begin
        if (bus.done_i) begin
          icnt_d = icnt_q + 8'd1;
          if (eligible) begin
            issue = 1'b1;
          end else begin
            state_d = S_IDLE;
            din_d   = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (issue) begin
      pop     = 1'b1;
      din_d   = head;
      run_d   = 1'b1;
      mvi_d   = (head_op == OP_MVI);
      state_d = S_ISSUE;
    end
    busy_d  = (state_d != S_IDLE);
    count_d = count_q + CW'(push) - CW'(pop);
    full_d  = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      din_q   <= '0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
      icnt_q  <= '0;
      mvi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= full_d;
      din_q   <= din_d;
      run_q   <= run_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
      icnt_q  <= icnt_d;
      mvi_q   <= mvi_d;
    end
  end

  // Storage carries no reset; occupancy alone defines valid words.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus.wr_data_i;
  end

  assign bus.full_o      = full_q;
  assign bus.count_o     = count_q;
  assign bus.din_o       = din_q;
  assign bus.run_o       = run_q;
  assign bus.busy_o      = busy_q;
  assign bus.drop_err_o  = drop_q;
  assign bus.instr_cnt_o = icnt_q;
endmodule

// File: tb/tb_instr_issuer.sv
// Bench for instr_issuer: randomized programs against a cycle-timeline reference model.
module tb_instr_issuer;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;
  localparam int MAXC = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_issuer_if #(.AW(AW)) bif();

`ifdef INSTR_ISSUER_SINGLE_STEP_EN
  logic step;
  instr_issuer #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst(rst), .step_i(step), .bus(bif));
`else
  instr_issuer #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bif));
`endif

  // Processor model: T0 samples Run and latches DIN into IR; Done in T1 (MV/MVI) or T3 (ADD/SUB).
  logic [1:0] pt;
  logic [8:0] ir;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pt <= 2'd0;
      ir <= 9'd0;
    end else if (pt == 2'd0) begin
      if (bif.run_o) begin
        ir <= bif.din_o;
        pt <= 2'd1;
      end
    end else if (bif.done_i) begin
      pt <= 2'd0;
    end else begin
      pt <= pt + 2'd1;
    end
  end
  assign bif.done_i = ((pt == 2'd1) && !ir[7]) || ((pt == 2'd3) && ir[7]);

  int n_chk  = 0;
  int n_fail = 0;
  int exp_icnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [8:0] w);
    bif.wr_data_i = w;
    bif.wr_en_i   = 1'b1;
    tick();
    bif.wr_en_i   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bif.go_i = 1'b0;
    bif.wr_en_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_icnt = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_din"},   32'(bif.din_o), 32'h0);
    chk({tag, "_run"},   32'(bif.run_o), 32'h0);
    chk({tag, "_busy"},  32'(bif.busy_o), 32'h0);
    chk({tag, "_drop"},  32'(bif.drop_err_o), 32'h0);
    chk({tag, "_icnt"},  32'(bif.instr_cnt_o), 32'h0);
    chk({tag, "_count"}, 32'(bif.count_o), 32'h0);
    chk({tag, "_full"},  32'(bif.full_o), 32'h0);
  endtask

  // Stock the FIFO with Go=0, raise Go and compare every cycle with a timeline
  // derived from the issue rules: drops cost one IDLE cycle, MV/MVI occupy 2 cycles,
  // ADD/SUB 4, back-to-back issue on Done, one extra IDLE cycle after Done when the
  // next head must first be dropped.
  task automatic run_prog(input string name, input logic [8:0] prog [$]);
    bit e_run [MAXC];
    bit e_busy [MAXC];
    bit e_drop [MAXC];
    bit e_dinv [MAXC];
    logic [8:0] e_din [MAXC];
    int pops [MAXC];
    int t, d, i, n, len, r, last, n_ok, cnt;
    bit in_wait;
    logic [8:0] w;
    for (int c = 0; c < MAXC; c++) begin
      e_run[c] = 0; e_busy[c] = 0; e_drop[c] = 0; e_dinv[c] = 0; e_din[c] = '0; pops[c] = 0;
    end
    t = 0; d = 0; i = 0; n = prog.size(); in_wait = 0; n_ok = 0;
    while (i < n) begin
      w = prog[i];
      if (w[8]) begin
        if (in_wait) begin
          t = d + 1;
          in_wait = 0;
        end
        pops[t]++;
        e_drop[t+1] = 1;
        t++;
        i++;
      end else begin
        len = w[7] ? 4 : 2;
        r = t + 1;
        pops[t]++;
        e_run[r] = 1;
        for (int k = 0; k < len; k++) e_busy[r+k] = 1;
        e_dinv[r] = 1; e_din[r] = w;
        e_dinv[r+1] = 1;
        if (w[8:6] == 3'b001) begin
          pops[r]++;
          e_din[r+1] = prog[i+1];
          i += 2;
        end else begin
          e_din[r+1] = 9'h0;
          i++;
        end
        d = r + len - 1;
        t = d;
        in_wait = 1;
        n_ok++;
      end
    end
    last = (in_wait ? d : t) + 3;

    bif.go_i = 1'b0;
    for (int k = 0; k < n; k++) push(prog[k]);
    bif.go_i = 1'b1;
    cnt = n;
    for (int c = 0; c < last; c++) begin
      @(negedge clk);
      chk($sformatf("%s_run@%0d", name, c), 32'(bif.run_o), 32'(e_run[c]));
      chk($sformatf("%s_busy@%0d", name, c), 32'(bif.busy_o), 32'(e_busy[c]));
      chk($sformatf("%s_drop@%0d", name, c), 32'(bif.drop_err_o), 32'(e_drop[c]));
      chk($sformatf("%s_count@%0d", name, c), 32'(bif.count_o), 32'(cnt));
      if (e_dinv[c]) chk($sformatf("%s_din@%0d", name, c), 32'(bif.din_o), 32'(e_din[c]));
      cnt -= pops[c];
      tick();
    end
    bif.go_i = 1'b0;
    exp_icnt = (exp_icnt + n_ok) % 256;
    chk({name, "_icnt"}, 32'(bif.instr_cnt_o), 32'(exp_icnt));
  endtask

  task automatic gen_prog(output logic [8:0] p [$]);
    int target, k;
    p = {};
    target = $urandom_range(1, 8);
    while (p.size() < target) begin
      k = $urandom_range(0, 5);
      if (k == 1 && p.size() > 6) k = 0;
      if (k >= 4) begin
        p.push_back({1'b1, 8'($urandom)});
      end else begin
        p.push_back({3'(k), 6'($urandom)});
        if (k == 1) p.push_back(9'($urandom));
      end
    end
  endtask

  task automatic drop_test();
    bif.go_i = 1'b1;
    push(9'h1FF);
    @(negedge clk);
    chk("drop_cnt_before", 32'(bif.count_o), 32'd1);
    chk("drop_pulse_before", 32'(bif.drop_err_o), 32'd0);
    tick();
    @(negedge clk);
    chk("drop_pulse", 32'(bif.drop_err_o), 32'd1);
    chk("drop_cnt_after", 32'(bif.count_o), 32'd0);
    chk("drop_run", 32'(bif.run_o), 32'd0);
    tick();
    @(negedge clk);
    chk("drop_pulse_end", 32'(bif.drop_err_o), 32'd0);
    bif.go_i = 1'b0;
  endtask

  task automatic full_reset_test();
    bif.go_i = 1'b0;
    for (int k = 0; k < 9; k++) push(9'h080 + 9'(k));
    @(negedge clk);
    chk("full_flag", 32'(bif.full_o), 32'd1);
    chk("full_count", 32'(bif.count_o), 32'd8);
    push(9'h0AA);
    @(negedge clk);
    chk("full_count_hold", 32'(bif.count_o), 32'd8);
`ifdef INSTR_ISSUER_SINGLE_STEP_EN
    step = 1'b1;
    tick();
    step = 1'b0;
`endif
    bif.go_i = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("midwait_busy", 32'(bif.busy_o), 32'd1);
    chk("midwait_run", 32'(bif.run_o), 32'd0);
    rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    tick();
    rst = 1'b0;
    bif.go_i = 1'b0;
    exp_icnt = 0;
  endtask

  initial begin
    logic [8:0] q [$];
    int runs;
`ifdef INSTR_ISSUER_SINGLE_STEP_EN
    step = 1'b0;
`endif
    bif.wr_data_i = '0;
    do_reset();
    chk_reset_vals("reset");

`ifndef INSTR_ISSUER_SINGLE_STEP_EN
    // MVI waits for its immediate; Run follows the cycle the immediate lands.
    bif.go_i = 1'b1;
    push(9'h040);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("starve_run@%0d", k), 32'(bif.run_o), 32'd0);
      tick();
    end
    push(9'h07F);
    @(negedge clk);
    chk("starve_run_edge", 32'(bif.run_o), 32'd0);
    chk("starve_cnt2", 32'(bif.count_o), 32'd2);
    tick();
    @(negedge clk);
    chk("starve_run_hi", 32'(bif.run_o), 32'd1);
    chk("starve_din_op", 32'(bif.din_o), 32'h040);
    tick();
    @(negedge clk);
    chk("starve_din_imm", 32'(bif.din_o), 32'h07F);
    chk("starve_cnt0", 32'(bif.count_o), 32'd0);
    for (int k = 0; k < 20 && bif.busy_o; k++) tick();
    chk("starve_drain", 32'(bif.busy_o), 32'd0);
    bif.go_i = 1'b0;
    exp_icnt++;
    chk("starve_icnt", 32'(bif.instr_cnt_o), 32'(exp_icnt));

    q = {}; q.push_back(9'h008); q.push_back(9'h011);
    run_prog("mv_b2b", q);
    q = {}; q.push_back(9'h058); q.push_back(9'h1A5);
    run_prog("mvi", q);
    q = {}; q.push_back(9'b010_001_010); q.push_back(9'b011_011_100);
    run_prog("add_sub", q);
    q = {}; q.push_back(9'h008); q.push_back(9'h1C3); q.push_back(9'h13F); q.push_back(9'h0A1);
    run_prog("mv_drop_add", q);
    for (int b = 0; b < 25; b++) begin
      gen_prog(q);
      run_prog($sformatf("rnd%0d", b), q);
    end
    drop_test();
    full_reset_test();
`else
    drop_test();
    push(9'h008); push(9'h008); push(9'h008);
    bif.go_i = 1'b1;
    runs = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bif.run_o) runs++;
      tick();
    end
    chk("step_no_token_runs", 32'(runs), 32'd0);
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bif.run_o) runs++;
      tick();
    end
    chk("step_runs", 32'(runs), 32'd1);
    chk("step_icnt", 32'(bif.instr_cnt_o), 32'd1);
    chk("step_count", 32'(bif.count_o), 32'd2);
    do_reset();
    full_reset_test();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
